// File: rtl/equiv_run_ctrl.sv
// equiv_run_ctrl: sequencer for the dual-instance equivalence harness.
// It drives a pseudo-random stimulus stream from a 64-bit Galois LFSR into
// both DUT copies and waits out a warm-up window. It then compares y_1 against
// y_2 once per cycle for a bounded run. On the first mismatch it stops and
// latches debug data. A clean run ends in PASS.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start, seed       launch a run (sampled in IDLE/PASS/FAIL), LFSR seed
//   wire0..wire3      stimulus slices of the LFSR register (unregistered slices)
//   y_1, y_2          outputs of the two DUT instances
//   busy              high in WARMUP or RUN
//   done              one-cycle pulse on entry to PASS or FAIL
//   pass, fail        sticky result flags
//   cycle_cnt         compared cycles completed in the current/last run
//   fail_cycle        RUN cycle index of the first mismatch
//   fail_stim         {wire0,wire1,wire2,wire3} at the mismatch
//   fail_diff         y_1 ^ y_2 at the mismatch
module equiv_run_ctrl #(
  parameter int unsigned Y_W        = 91,
  parameter int unsigned WARMUP     = 4,
  parameter int unsigned MAX_CYCLES = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      seed,
  output logic [17:0]      wire3,
  output logic [7:0]       wire2,
  output logic [21:0]      wire1,
  output logic [5:0]       wire0,
  input  logic [Y_W-1:0]   y_1,
  input  logic [Y_W-1:0]   y_2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] fail_cycle,
  output logic [53:0]      fail_stim,
  output logic [Y_W-1:0]   fail_diff
);

  localparam int unsigned LFSR_W = 64;
  localparam int unsigned STIM_W = 54;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [LFSR_W-1:0] LFSR_ONE  = 64'h1;
  localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_RUN    = 3'd2,
    S_PASS   = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [CNT_W-1:0]  warm_q, warm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  fail_cycle_q, fail_cycle_d;
  logic [STIM_W-1:0] fail_stim_q, fail_stim_d;
  logic [Y_W-1:0]    fail_diff_q, fail_diff_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;

  logic [STIM_W-1:0] stim;
  logic [Y_W-1:0]    diff;
  logic              mismatch;

  // Stimulus is the low 54 LFSR bits, so {wire0,wire1,wire2,wire3} == lfsr[53:0]
  assign stim      = lfsr_q[STIM_W-1:0];
  assign diff      = y_1 ^ y_2;
  assign mismatch  = (diff != '0);
  assign lfsr_step = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a mismatch on the final cycle takes priority over PASS
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) state_d = S_WARMUP;
      end
      S_WARMUP: begin
        if (warm_q == WARM_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (mismatch) begin
          state_d = S_FAIL;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_PASS;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values, registered below
  always_comb begin
    lfsr_d       = lfsr_q;
    warm_d       = warm_q;
    cnt_d        = cnt_q;
    fail_cycle_d = fail_cycle_q;
    fail_stim_d  = fail_stim_q;
    fail_diff_d  = fail_diff_q;
    done_d       = 1'b0;
    busy_d       = (state_d == S_WARMUP) || (state_d == S_RUN);
    pass_d       = (state_d == S_PASS);
    fail_d       = (state_d == S_FAIL);
    unique case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        // Fail capture registers survive a restart until the next mismatch
        if (start) begin
          lfsr_d = (seed == '0) ? LFSR_ONE : seed;
          warm_d = '0;
          cnt_d  = '0;
        end
      end
      S_WARMUP: begin
        lfsr_d = lfsr_step;
        warm_d = warm_q + CNT_W'(1);
      end
      S_RUN: begin
        lfsr_d = lfsr_step;
        if (mismatch) begin
          done_d       = 1'b1;
          fail_cycle_d = cnt_q;
          fail_stim_d  = stim;
          fail_diff_d  = diff;
        end else if (cnt_q == CNT_LAST) begin
          done_d = 1'b1;
          cnt_d  = CNT_FULL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q       <= LFSR_ONE;
      warm_q       <= '0;
      cnt_q        <= '0;
      fail_cycle_q <= '0;
      fail_stim_q  <= '0;
      fail_diff_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      warm_q       <= warm_d;
      cnt_q        <= cnt_d;
      fail_cycle_q <= fail_cycle_d;
      fail_stim_q  <= fail_stim_d;
      fail_diff_q  <= fail_diff_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
    end
  end

  assign wire3      = lfsr_q[17:0];
  assign wire2      = lfsr_q[25:18];
  assign wire1      = lfsr_q[47:26];
  assign wire0      = lfsr_q[53:48];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign cycle_cnt  = cnt_q;
  assign fail_cycle = fail_cycle_q;
  assign fail_stim  = fail_stim_q;
  assign fail_diff  = fail_diff_q;

endmodule

// File: tb/tb_equiv_run_ctrl.sv
// Self-checking bench for equiv_run_ctrl with a short warm-up and run length.
module tb_equiv_run_ctrl;

  localparam int unsigned Y_W        = 91;
  localparam int unsigned WARMUP     = 2;
  localparam int unsigned MAX_CYCLES = 16;
  localparam int unsigned CNT_W      = 16;
  localparam int          TIMEOUT    = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [63:0]      seed = '0;
  logic [17:0]      wire3;
  logic [7:0]       wire2;
  logic [21:0]      wire1;
  logic [5:0]       wire0;
  logic [Y_W-1:0]   y_1 = '0;
  logic [Y_W-1:0]   y_2 = '0;
  logic             busy, done, pass, fail;
  logic [CNT_W-1:0] cycle_cnt, fail_cycle;
  logic [53:0]      fail_stim;
  logic [Y_W-1:0]   fail_diff;

  int n_vec = 0;
  int n_err = 0;
  logic [Y_W-1:0] inj_mask;

  equiv_run_ctrl #(
    .Y_W(Y_W), .WARMUP(WARMUP), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .wire3(wire3), .wire2(wire2), .wire1(wire1), .wire0(wire0),
    .y_1(y_1), .y_2(y_2),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .cycle_cnt(cycle_cnt), .fail_cycle(fail_cycle),
    .fail_stim(fail_stim), .fail_diff(fail_diff)
  );

  always #5 clk = ~clk;

  // Reference LFSR: register contents k steps after the seed is loaded
  function automatic logic [63:0] lfsr_at(input logic [63:0] sd, input int k);
    logic [63:0] v;
    v = (sd == 64'h0) ? 64'h1 : sd;
    for (int i = 0; i < k; i++) v = (v >> 1) ^ (v[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    return v;
  endfunction

  function automatic logic [Y_W-1:0] rand_y();
    return Y_W'({$urandom, $urandom, $urandom});
  endfunction

  function automatic logic [63:0] rand_seed();
    return {$urandom, $urandom};
  endfunction

  // Edge 0 is the edge that accepts start. Mismatch is injected into the
  // cycle after edges inj_lo..inj_hi; rst is driven after edge rst_e.
  task automatic run_one(input logic [63:0] sd, input int inj_lo, input int inj_hi,
                         input int rst_e, input int start2_e,
                         output int end_edge, output int busy_cycles, output int done_cnt);
    logic [63:0]    ref_l;
    logic [Y_W-1:0] r;
    logic           was_rst;
    end_edge = -1; busy_cycles = 0; done_cnt = 0; was_rst = 1'b0;
    seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 0; e <= TIMEOUT; e++) begin
      ref_l = lfsr_at(sd, e);
      n_vec++;
      if ({wire0, wire1, wire2, wire3} !== ref_l[53:0]) begin
        n_err++;
        $display("FAIL stim edge %0d: got %h want %h", e, {wire0, wire1, wire2, wire3}, ref_l[53:0]);
      end
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        end_edge = e;
        break;
      end
      r = rand_y();
      y_1 = r;
      y_2 = (e >= inj_lo && e <= inj_hi) ? (r ^ inj_mask) : r;
      start = (e == start2_e);
      rst = (e == rst_e);
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0; was_rst = 1'b1; end_edge = e + 1;
        break;
      end
    end
    start = 1'b0;
    y_2 = y_1;
    if (end_edge < 0) begin
      n_vec++; n_err++;
      $display("FAIL timeout: no done within %0d edges", TIMEOUT);
    end
    if (!was_rst) begin
      repeat (3) begin
        @(posedge clk); #1;
        if (done) done_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({busy, done, pass, fail} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, fail});
    end
    n_vec++;
    if ({cycle_cnt, fail_cycle} !== '0 || fail_stim !== '0 || fail_diff !== '0) begin
      n_err++; $display("FAIL reset_regs: cnt %0d fcyc %0d stim %h diff %h want all 0",
                        cycle_cnt, fail_cycle, fail_stim, fail_diff);
    end
    n_vec++;
    if ({wire0, wire1, wire2, wire3} !== 54'h1) begin
      n_err++; $display("FAIL reset_stim: got %h want 1", {wire0, wire1, wire2, wire3});
    end
  endtask

  task automatic test_pass();
    int ee, bc, dc;
    run_one(64'h1, -1, -1, -1, -1, ee, bc, dc);
    n_vec++;
    if (ee != int'(WARMUP + MAX_CYCLES) || bc != int'(WARMUP + MAX_CYCLES) || dc != 1) begin
      n_err++; $display("FAIL pass_timing: end %0d busy %0d done %0d want %0d %0d 1",
                        ee, bc, dc, WARMUP + MAX_CYCLES, WARMUP + MAX_CYCLES);
    end
    n_vec++;
    if (pass !== 1'b1 || fail !== 1'b0 || cycle_cnt !== CNT_W'(MAX_CYCLES)) begin
      n_err++; $display("FAIL pass_result: pass %b fail %b cnt %0d want 1 0 %0d",
                        pass, fail, cycle_cnt, MAX_CYCLES);
    end
  endtask

  task automatic test_fail_mid();
    int ee, bc, dc;
    logic [63:0] ref_l;
    inj_mask = Y_W'(1);
    run_one(64'h1, WARMUP + 5, WARMUP + 5, -1, -1, ee, bc, dc);
    ref_l = lfsr_at(64'h1, WARMUP + 5);
    n_vec++;
    if (ee != int'(WARMUP + 6) || dc != 1) begin
      n_err++; $display("FAIL fmid_timing: end %0d done %0d want %0d 1", ee, dc, WARMUP + 6);
    end
    n_vec++;
    if (fail !== 1'b1 || pass !== 1'b0 || fail_cycle !== CNT_W'(5) || cycle_cnt !== CNT_W'(5)) begin
      n_err++; $display("FAIL fmid_result: fail %b pass %b fcyc %0d cnt %0d want 1 0 5 5",
                        fail, pass, fail_cycle, cycle_cnt);
    end
    n_vec++;
    if (fail_diff !== Y_W'(1) || fail_stim !== ref_l[53:0]) begin
      n_err++; $display("FAIL fmid_capture: diff %h stim %h want 1 %h", fail_diff, fail_stim, ref_l[53:0]);
    end
  endtask

  task automatic test_warmup_ignored();
    int ee, bc, dc;
    inj_mask = rand_y() | Y_W'(1);
    run_one(rand_seed(), 0, WARMUP - 1, -1, -1, ee, bc, dc);
    n_vec++;
    if (pass !== 1'b1 || fail !== 1'b0 || ee != int'(WARMUP + MAX_CYCLES) || dc != 1) begin
      n_err++; $display("FAIL warmup_ignored: pass %b fail %b end %0d done %0d want 1 0 %0d 1",
                        pass, fail, ee, dc, WARMUP + MAX_CYCLES);
    end
    n_vec++;
    if (fail_cycle !== CNT_W'(5) || fail_diff !== Y_W'(1)) begin
      n_err++; $display("FAIL capture_kept: fcyc %0d diff %h want 5 1", fail_cycle, fail_diff);
    end
  endtask

  task automatic test_fail_last();
    int ee, bc, dc;
    logic [63:0] sd, ref_l;
    logic [Y_W-1:0] m;
    sd = rand_seed();
    m = rand_y();
    if (m == '0) m = Y_W'(1);
    inj_mask = m;
    run_one(sd, WARMUP + MAX_CYCLES - 1, WARMUP + MAX_CYCLES - 1, -1, -1, ee, bc, dc);
    ref_l = lfsr_at(sd, WARMUP + MAX_CYCLES - 1);
    n_vec++;
    if (fail !== 1'b1 || pass !== 1'b0 || fail_cycle !== CNT_W'(MAX_CYCLES - 1) || dc != 1) begin
      n_err++; $display("FAIL flast_result: fail %b pass %b fcyc %0d done %0d want 1 0 %0d 1",
                        fail, pass, fail_cycle, dc, MAX_CYCLES - 1);
    end
    n_vec++;
    if (fail_diff !== m || fail_stim !== ref_l[53:0] || cycle_cnt !== CNT_W'(MAX_CYCLES - 1)) begin
      n_err++; $display("FAIL flast_capture: diff %h stim %h cnt %0d want %h %h %0d",
                        fail_diff, fail_stim, cycle_cnt, m, ref_l[53:0], MAX_CYCLES - 1);
    end
  endtask

  task automatic test_seed_zero_restart();
    int ee, bc, dc;
    logic [63:0] one_step;
    run_one(64'h0, -1, -1, -1, WARMUP + 6, ee, bc, dc);
    one_step = lfsr_at(64'h1, WARMUP + MAX_CYCLES);
    n_vec++;
    if (pass !== 1'b1 || dc != 1 || ee != int'(WARMUP + MAX_CYCLES)) begin
      n_err++; $display("FAIL seed0_restart: pass %b done %0d end %0d want 1 1 %0d",
                        pass, dc, ee, WARMUP + MAX_CYCLES);
    end
    n_vec++;
    if ({wire0, wire1, wire2, wire3} !== one_step[53:0]) begin
      n_err++; $display("FAIL seed0_final_stim: got %h want %h", {wire0, wire1, wire2, wire3}, one_step[53:0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int ee, bc, dc;
    run_one(rand_seed(), -1, -1, WARMUP + 8, -1, ee, bc, dc);
    n_vec++;
    if ({busy, done, pass, fail} !== 4'b0000 || ee != int'(WARMUP + 9)) begin
      n_err++; $display("FAIL rst_mid_flags: got %b end %0d want 0000 %0d", {busy, done, pass, fail}, ee, WARMUP + 9);
    end
    n_vec++;
    if ({cycle_cnt, fail_cycle} !== '0 || fail_stim !== '0 || fail_diff !== '0
        || {wire0, wire1, wire2, wire3} !== 54'h1) begin
      n_err++; $display("FAIL rst_mid_regs: cnt %0d fcyc %0d stim %h diff %h lfsr %h want 0 0 0 0 1",
                        cycle_cnt, fail_cycle, fail_stim, fail_diff, {wire0, wire1, wire2, wire3});
    end
    run_one(rand_seed(), -1, -1, -1, -1, ee, bc, dc);
    n_vec++;
    if (pass !== 1'b1 || fail !== 1'b0 || cycle_cnt !== CNT_W'(MAX_CYCLES) || dc != 1
        || bc != int'(WARMUP + MAX_CYCLES)) begin
      n_err++; $display("FAIL rst_fresh_run: pass %b fail %b cnt %0d done %0d busy %0d want 1 0 %0d 1 %0d",
                        pass, fail, cycle_cnt, dc, bc, MAX_CYCLES, WARMUP + MAX_CYCLES);
    end
  endtask

  initial begin
    inj_mask = Y_W'(1);
    test_reset();
    test_pass();
    test_fail_mid();
    test_warmup_ignored();
    test_fail_last();
    test_seed_zero_restart();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
